// File: rtl/fractal_pipeline_scheduler_if.sv
// ============================================================================
//  Module      : fractal_pipeline_scheduler_if
//  Description : Bundles the pixel input stream, finished-pixel output stream
//                and the fractal_kernel datapath seen by the scheduler.
//                master = scheduler side, slave = surrounding logic side.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface fractal_pipeline_scheduler_if #(
  parameter int DATA_WIDTH = 32,
  parameter int TAG_WIDTH  = 20
);
  // Pixel input stream from the coordinate generator
  logic                  s_valid;
  logic                  s_ready;
  logic [DATA_WIDTH-1:0] s_cr;
  logic [DATA_WIDTH-1:0] s_ci;
  logic [TAG_WIDTH-1:0]  s_tag;

  // Finished pixel stream towards the colour mapper
  logic                  m_valid;
  logic                  m_ready;
  logic [7:0]            m_iter;
  logic [TAG_WIDTH-1:0]  m_tag;

  // Kernel inputs
  logic [DATA_WIDTH-1:0] k_zr_in;
  logic [DATA_WIDTH-1:0] k_zi_in;
  logic [DATA_WIDTH-1:0] k_cr_in;
  logic [DATA_WIDTH-1:0] k_ci_in;
  logic [7:0]            k_iter_in;
  logic                  k_finished_in;
  logic                  k_inc_enabled;

  // Kernel outputs
  logic [DATA_WIDTH-1:0] k_zr_out;
  logic [DATA_WIDTH-1:0] k_zi_out;
  logic [DATA_WIDTH-1:0] k_cr_out;
  logic [DATA_WIDTH-1:0] k_ci_out;
  logic [7:0]            k_iter_out;
  logic                  k_finished_out;

  modport master (
    input  s_valid, s_cr, s_ci, s_tag,
    output s_ready,
    output m_valid, m_iter, m_tag,
    input  m_ready,
    output k_zr_in, k_zi_in, k_cr_in, k_ci_in, k_iter_in, k_finished_in, k_inc_enabled,
    input  k_zr_out, k_zi_out, k_cr_out, k_ci_out, k_iter_out, k_finished_out
  );

  modport slave (
    output s_valid, s_cr, s_ci, s_tag,
    input  s_ready,
    input  m_valid, m_iter, m_tag,
    output m_ready,
    input  k_zr_in, k_zi_in, k_cr_in, k_ci_in, k_iter_in, k_finished_in, k_inc_enabled,
    output k_zr_out, k_zi_out, k_cr_out, k_ci_out, k_iter_out, k_finished_out
  );
endinterface

`default_nettype wire

// File: rtl/fractal_pipeline_scheduler.sv
// ============================================================================
//  Module      : fractal_pipeline_scheduler
//  Description : Keeps the fixed-latency fractal kernel loop full. Each of the
//                KERNEL_LATENCY cycles of the loop is a slot; a slot returning
//                from the kernel is either recirculated, retired into a
//                1-entry output register, or freed for a new pixel.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module fractal_pipeline_scheduler #(
  parameter int KERNEL_LATENCY = 8,
  parameter int DATA_WIDTH     = 32,
  parameter int TAG_WIDTH      = 20
) (
  input  logic                         clk,
  input  logic                         reset,
  fractal_pipeline_scheduler_if.master io,
  output logic                         busy
);

  localparam int LAST = KERNEL_LATENCY - 1;

  // Slot bookkeeping travelling alongside the kernel (the kernel itself has no reset)
  logic [KERNEL_LATENCY-1:0] vld_pipe_q, vld_pipe_d;
  logic [TAG_WIDTH-1:0]      tag_pipe_q [KERNEL_LATENCY];
  logic [TAG_WIDTH-1:0]      tag_pipe_d [KERNEL_LATENCY];

  // Output skid register
  logic                 m_valid_q, m_valid_d;
  logic [7:0]           m_iter_q,  m_iter_d;
  logic [TAG_WIDTH-1:0] m_tag_q,   m_tag_d;

  // Decisions for the slot currently returning from the kernel
  logic                 ret_vld;
  logic [TAG_WIDTH-1:0] ret_tag;
  logic                 out_free;
  logic                 recirc;
  logic                 retire;
  logic                 slot_free;
  logic                 inject;

  // Classify the returning slot; a slot is free unless it has to go round again
  always_comb begin
    ret_vld   = vld_pipe_q[LAST];
    ret_tag   = tag_pipe_q[LAST];
    out_free  = !m_valid_q || io.m_ready;
    // Unfinished slots always recirculate; finished ones recirculate only
    // while the output register is occupied and not draining.
    recirc    = ret_vld && (!io.k_finished_out || !out_free);
    retire    = ret_vld && io.k_finished_out && out_free;
    slot_free = !recirc;
    inject    = slot_free && io.s_valid;
  end

  assign io.s_ready = slot_free;

  // Kernel input mux: recirculate, inject a new pixel, or send a zeroed bubble
  always_comb begin
    io.k_zr_in       = '0;
    io.k_zi_in       = '0;
    io.k_cr_in       = '0;
    io.k_ci_in       = '0;
    io.k_iter_in     = '0;
    io.k_finished_in = 1'b0;
    io.k_inc_enabled = 1'b0;
    if (recirc) begin
      io.k_zr_in       = io.k_zr_out;
      io.k_zi_in       = io.k_zi_out;
      io.k_cr_in       = io.k_cr_out;
      io.k_ci_in       = io.k_ci_out;
      io.k_iter_in     = io.k_iter_out;
      // A finished slot parked in the loop keeps finished=1 so its iter is held
      io.k_finished_in = io.k_finished_out;
      io.k_inc_enabled = 1'b1;
    end else if (inject) begin
      io.k_cr_in       = io.s_cr;
      io.k_ci_in       = io.s_ci;
      io.k_inc_enabled = 1'b1;
    end
  end

  // Next slot state: head of the pipe takes the recirculated or injected slot
  always_comb begin
    vld_pipe_d    = '0;
    vld_pipe_d[0] = recirc || inject;
    tag_pipe_d[0] = '0;
    if (recirc) begin
      tag_pipe_d[0] = ret_tag;
    end else if (inject) begin
      tag_pipe_d[0] = io.s_tag;
    end
    for (int i = 1; i < KERNEL_LATENCY; i++) begin
      vld_pipe_d[i] = vld_pipe_q[i-1];
      tag_pipe_d[i] = tag_pipe_q[i-1];
    end
  end

  // Output register: load on retire, otherwise clear valid once drained
  always_comb begin
    m_valid_d = m_valid_q;
    m_iter_d  = m_iter_q;
    m_tag_d   = m_tag_q;
    if (retire) begin
      m_valid_d = 1'b1;
      m_iter_d  = io.k_iter_out;
      m_tag_d   = ret_tag;
    end else if (io.m_ready) begin
      m_valid_d = 1'b0;
    end
  end

  // Control state with synchronous reset; reset discards every in-flight slot
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_pipe_q <= '0;
      m_valid_q  <= 1'b0;
      m_iter_q   <= '0;
      m_tag_q    <= '0;
    end else begin
      vld_pipe_q <= vld_pipe_d;
      m_valid_q  <= m_valid_d;
      m_iter_q   <= m_iter_d;
      m_tag_q    <= m_tag_d;
    end
  end

  // Tags are qualified by vld_pipe_q, so they need no reset
  always_ff @(posedge clk) begin
    for (int i = 0; i < KERNEL_LATENCY; i++) begin
      tag_pipe_q[i] <= tag_pipe_d[i];
    end
  end

  assign io.m_valid = m_valid_q;
  assign io.m_iter  = m_iter_q;
  assign io.m_tag   = m_tag_q;

  assign busy = (|vld_pipe_q) || m_valid_q;

endmodule

`default_nettype wire

// File: tb/tb_fractal_pipeline_scheduler.sv
// ============================================================================
//  Module      : tb_fractal_pipeline_scheduler
//  Description : Directed bench for fractal_pipeline_scheduler with a
//                behavioural Mandelbrot kernel (Q4.28, latency L) in the loop.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_fractal_pipeline_scheduler;

  localparam int L  = 8;
  localparam int DW = 32;
  localparam int TW = 20;
  localparam logic [31:0] C_TWO  = 32'h2000_0000;  // 2.0 in Q4.28
  localparam logic [31:0] C_ZERO = 32'h0000_0000;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  logic busy;

  always #5 clk = ~clk;

  fractal_pipeline_scheduler_if #(.DATA_WIDTH(DW), .TAG_WIDTH(TW)) ifc ();

  fractal_pipeline_scheduler #(
    .KERNEL_LATENCY(L),
    .DATA_WIDTH    (DW),
    .TAG_WIDTH     (TW)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .io   (ifc),
    .busy (busy)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural kernel: z' = z^2 + c, escape test on incoming z (|z|^2 > 4),
  // iter counts every unfinished pass, forced finish at iter 255.
  logic [31:0] kzr [L];
  logic [31:0] kzi [L];
  logic [31:0] kcr [L];
  logic [31:0] kci [L];
  logic [7:0]  kit [L];
  logic        kfin[L];

  always @(posedge clk) begin
    longint a, b, rr, ii, ri, cr, ci;
    logic [7:0] nit;
    a  = longint'($signed(ifc.k_zr_in));
    b  = longint'($signed(ifc.k_zi_in));
    cr = longint'($signed(ifc.k_cr_in));
    ci = longint'($signed(ifc.k_ci_in));
    rr = a * a;
    ii = b * b;
    ri = a * b;
    for (int i = L - 1; i > 0; i--) begin
      kzr[i] <= kzr[i-1]; kzi[i] <= kzi[i-1]; kcr[i] <= kcr[i-1];
      kci[i] <= kci[i-1]; kit[i] <= kit[i-1]; kfin[i] <= kfin[i-1];
    end
    kcr[0] <= ifc.k_cr_in;
    kci[0] <= ifc.k_ci_in;
    if (ifc.k_finished_in) begin
      kzr[0]  <= ifc.k_zr_in;
      kzi[0]  <= ifc.k_zi_in;
      kit[0]  <= ifc.k_iter_in;
      kfin[0] <= 1'b1;
    end else begin
      nit     = ifc.k_iter_in + (ifc.k_inc_enabled ? 8'd1 : 8'd0);
      kzr[0]  <= 32'(((rr - ii) >>> 28) + cr);
      kzi[0]  <= 32'(((2 * ri) >>> 28) + ci);
      kit[0]  <= nit;
      kfin[0] <= ((rr + ii) > (longint'(4) <<< 56)) || (nit == 8'd255);
    end
  end

  assign ifc.k_zr_out       = kzr[L-1];
  assign ifc.k_zi_out       = kzi[L-1];
  assign ifc.k_cr_out       = kcr[L-1];
  assign ifc.k_ci_out       = kci[L-1];
  assign ifc.k_iter_out     = kit[L-1];
  assign ifc.k_finished_out = kfin[L-1];

  // Log every completed output handshake (sampled mid-cycle, completes at next edge)
  logic [TW-1:0] out_tag [$];
  logic [7:0]    out_iter[$];

  always @(negedge clk) begin
    if (!reset && ifc.m_valid && ifc.m_ready) begin
      out_tag.push_back(ifc.m_tag);
      out_iter.push_back(ifc.m_iter);
    end
  end

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", name, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offer one pixel until accepted; acc = edge count of the accepting edge
  task automatic send_one(input logic [31:0] cr, input logic [TW-1:0] tag, output int acc);
    logic hs;
    ifc.s_cr    = cr;
    ifc.s_ci    = '0;
    ifc.s_tag   = tag;
    ifc.s_valid = 1'b1;
    acc = -1;
    for (int g = 0; g < 4000 && acc < 0; g++) begin
      #1;
      hs = ifc.s_ready;
      step();
      if (hs) acc = cyc;
    end
    ifc.s_valid = 1'b0;
    check("send_accepted", 32'(acc >= 0), 32'd1);
  endtask

  task automatic wait_mvalid(input int bound, output int at);
    for (int g = 0; g < bound && !ifc.m_valid; g++) step();
    at = cyc;
    check("mvalid_seen", 32'(ifc.m_valid), 32'd1);
  endtask

  task automatic wait_outputs(input int n, input int bound);
    for (int g = 0; g < bound && out_tag.size() < n; g++) step();
    check("output_count", 32'(out_tag.size()), 32'(n));
  endtask

  task automatic wait_idle();
    for (int g = 0; g < 5000 && busy; g++) step();
    #1;
    check("idle", 32'(busy), 32'd0);
  endtask

  initial begin
    int a, at;
    int acc[10];
    logic [7:0] mask;
    logic stable;

    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int a, at;
    int acc[10];
    logic [7:0] mask;
    logic stable;
    int idx;

    ifc.s_valid = 1'b0;
    ifc.s_cr    = '0;
    ifc.s_ci    = '0;
    ifc.s_tag   = '0;
    ifc.m_ready = 1'b1;
    repeat (3) step();
    reset = 1'b0;
    #1;

    // Reset state
    check("rst_busy",    32'(busy),        32'd0);
    check("rst_m_valid", 32'(ifc.m_valid), 32'd0);
    check("rst_m_iter",  32'(ifc.m_iter),  32'd0);
    check("rst_m_tag",   32'(ifc.m_tag),   32'd0);
    check("rst_s_ready", 32'(ifc.s_ready), 32'd1);

    // c = 2.0: passes see z = 0, 2, 6 -> iter 3; m_valid appears 3L edges
    // after the accepting edge (cycle accept + 3L + 1)
    out_tag.delete(); out_iter.delete();
    send_one(C_TWO, 20'd7, a);
    wait_mvalid(200, at);
    check("c2_latency", 32'(at - a), 32'(3 * L));
    check("c2_iter",    32'(ifc.m_iter), 32'd3);
    check("c2_tag",     32'(ifc.m_tag),  32'd7);
    wait_idle();
    check("c2_count", 32'(out_tag.size()), 32'd1);

    // c = 0: never escapes, forced finish after 255 passes
    out_tag.delete(); out_iter.delete();
    send_one(C_ZERO, 20'd5, a);
    wait_mvalid(255 * L + 100, at);
    check("c0_latency", 32'(at - a), 32'(255 * L));
    check("c0_iter",    32'(ifc.m_iter), 32'd255);
    check("c0_tag",     32'(ifc.m_tag),  32'd5);
    wait_idle();

    // Back-to-back stream of L+2 pixels: L fill the loop, the rest wait for a retire
    out_tag.delete(); out_iter.delete();
    for (int i = 0; i < L + 2; i++) send_one(C_TWO, 20'(100 + i), acc[i]);
    check("fill_consecutive", 32'(acc[L-1] - acc[0]), 32'(L - 1));
    check("fill_wait_retire", 32'(acc[L]   - acc[0]), 32'(3 * L));
    check("fill_next_retire", 32'(acc[L+1] - acc[0]), 32'(3 * L + 1));
    wait_outputs(L + 2, 500);
    for (int i = 0; i < L + 2 && i < out_tag.size(); i++) begin
      check("fill_tag",  32'(out_tag[i]),  32'(100 + i));
      check("fill_iter", 32'(out_iter[i]), 32'd3);
    end
    wait_idle();

    // Backpressure: L finished pixels, m_ready low for 100 cycles
    out_tag.delete(); out_iter.delete();
    ifc.m_ready = 1'b0;
    for (int i = 0; i < L; i++) send_one(C_TWO, 20'(200 + i), acc[i]);
    wait_mvalid(200, at);
    stable = 1'b1;
    for (int i = 0; i < 100; i++) begin
      if (!(ifc.m_valid && ifc.m_tag == 20'd200 && ifc.m_iter == 8'd3)) stable = 1'b0;
      step();
    end
    check("hold_stable",       32'(stable),         32'd1);
    check("hold_no_handshake", 32'(out_tag.size()), 32'd0);
    ifc.m_ready = 1'b1;
    wait_outputs(L, 500);
    mask = '0;
    for (int i = 0; i < out_tag.size(); i++) begin
      idx = int'(out_tag[i]) - 200;
      if (idx >= 0 && idx < L) mask[idx] = 1'b1;
      check("hold_iter", 32'(out_iter[i]), 32'd3);
    end
    check("hold_all_tags", 32'(mask), 32'hFF);
    wait_idle();
    check("hold_no_dup", 32'(out_tag.size()), 32'(L));

    // Interleaved c=0 / c=2.0: the fast ones overtake
    out_tag.delete(); out_iter.delete();
    send_one(C_ZERO, 20'd300, a);
    send_one(C_TWO,  20'd301, a);
    send_one(C_ZERO, 20'd302, a);
    send_one(C_TWO,  20'd303, a);
    wait_outputs(4, 255 * L + 200);
    if (out_tag.size() >= 4) begin
      check("mix_tag0",  32'(out_tag[0]),  32'd301);
      check("mix_tag1",  32'(out_tag[1]),  32'd303);
      check("mix_tag2",  32'(out_tag[2]),  32'd300);
      check("mix_tag3",  32'(out_tag[3]),  32'd302);
      check("mix_iter0", 32'(out_iter[0]), 32'd3);
      check("mix_iter1", 32'(out_iter[1]), 32'd3);
      check("mix_iter2", 32'(out_iter[2]), 32'd255);
      check("mix_iter3", 32'(out_iter[3]), 32'd255);
    end
    wait_idle();

    // Reset mid-run with a finished pixel parked in the output register
    out_tag.delete(); out_iter.delete();
    ifc.m_ready = 1'b0;
    send_one(C_TWO,  20'd400, a);
    send_one(C_ZERO, 20'd401, a);
    wait_mvalid(200, at);
    reset = 1'b1;
    step();
    reset = 1'b0;
    #1;
    check("mid_rst_busy",    32'(busy),        32'd0);
    check("mid_rst_m_valid", 32'(ifc.m_valid), 32'd0);
    check("mid_rst_s_ready", 32'(ifc.s_ready), 32'd1);
    ifc.m_ready = 1'b1;
    repeat (255 * L + 100) step();
    check("mid_rst_no_output", 32'(out_tag.size()), 32'd0);
    check("mid_rst_idle",      32'(busy),           32'd0);
    send_one(C_TWO, 20'd410, a);
    wait_outputs(1, 200);
    if (out_tag.size() >= 1) begin
      check("post_rst_tag",  32'(out_tag[0]),  32'd410);
      check("post_rst_iter", 32'(out_iter[0]), 32'd3);
    end
    wait_idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
